// File: rtl/vga_timing_pkg.sv
// Shared raster constants and helpers for the VGA timing path.
// Holds the 1280x1024@60 defaults, a 640x480@60 bring-up set and the total-length helper.
package vga_timing_pkg;

  localparam int CNT_W     = 11;
  localparam int MAX_TOTAL = 2048;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [CNT_W:0]   cnt_ext_t;

  // 1280x1024 @ 60 Hz, 108 MHz pixel clock: 1688 x 1066
  localparam int DEF_H_VIS  = 1280;
  localparam int DEF_H_FP   = 48;
  localparam int DEF_H_SYNC = 112;
  localparam int DEF_H_BP   = 248;
  localparam int DEF_V_VIS  = 1024;
  localparam int DEF_V_FP   = 1;
  localparam int DEF_V_SYNC = 3;
  localparam int DEF_V_BP   = 38;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock: 800 x 525
  localparam int BRG_H_VIS  = 640;
  localparam int BRG_H_FP   = 16;
  localparam int BRG_H_SYNC = 96;
  localparam int BRG_H_BP   = 48;
  localparam int BRG_V_VIS  = 480;
  localparam int BRG_V_FP   = 10;
  localparam int BRG_V_SYNC = 2;
  localparam int BRG_V_BP   = 33;

  function automatic int calc_total(input int vis, input int fp, input int sync, input int bp);
    return vis + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-coordinate and sync bundle from the timing generator to the colour stage and DAC.
// master drives, slave observes.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  cnt_t x;
  cnt_t y;
  logic disp_en;
  logic line_start;
  logic frame_start;
  logic h_sync;
  logic v_sync;
  logic blank_n;

  modport master (output x, y, disp_en, line_start, frame_start, h_sync, v_sync, blank_n);
  modport slave  (input  x, y, disp_en, line_start, frame_start, h_sync, v_sync, blank_n);

endinterface

// File: rtl/vga_delay_line.sv
// Parametric-depth 1-bit shift register with async reset to RST_VAL.
// Latency DEPTH cycles (DEPTH=0 is a wire); free-running, no backpressure.
module vga_delay_line #(
  parameter int DEPTH   = 1,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign q = d;
  end else begin : g_shift
    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sr <= {DEPTH{RST_VAL}};
      end else begin
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++) begin
          sr[i] <= sr[i-1];
        end
      end
    end

    assign q = sr[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running h/v counters, registered x/y/disp_en one cycle behind them,
// syncs and blank_n a further SYNC_DLY cycles behind; no enable and no backpressure.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VIS    = DEF_H_VIS,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_VIS    = DEF_V_VIS,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit H_POL    = 1'b1,
  parameter bit V_POL    = 1'b1,
  parameter int SYNC_DLY = 1
) (
  input  logic             VGA_CLK,
  input  logic             rst_n,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = calc_total(H_VIS, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = calc_total(V_VIS, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_chk
    $error("vga_timing_gen: H_TOTAL=%0d V_TOTAL=%0d exceed %0d", H_TOTAL, V_TOTAL, MAX_TOTAL);
  end
  if (SYNC_DLY < 0 || SYNC_DLY > 4) begin : g_dly_chk
    $error("vga_timing_gen: SYNC_DLY=%0d outside 0..4", SYNC_DLY);
  end

  // One extra bit so a sync end of exactly 2048 still compares correctly.
  localparam cnt_ext_t H_LAST  = cnt_ext_t'(H_TOTAL - 1);
  localparam cnt_ext_t V_LAST  = cnt_ext_t'(V_TOTAL - 1);
  localparam cnt_ext_t H_VIS_C = cnt_ext_t'(H_VIS);
  localparam cnt_ext_t V_VIS_C = cnt_ext_t'(V_VIS);
  localparam cnt_ext_t HS_BEG  = cnt_ext_t'(H_VIS + H_FP);
  localparam cnt_ext_t HS_END  = cnt_ext_t'(H_VIS + H_FP + H_SYNC);
  localparam cnt_ext_t VS_BEG  = cnt_ext_t'(V_VIS + V_FP);
  localparam cnt_ext_t VS_END  = cnt_ext_t'(V_VIS + V_FP + V_SYNC);

  cnt_t     h_cnt, v_cnt;
  cnt_ext_t h_ext, v_ext;
  logic     h_wrap, v_wrap;
  logic     de_nxt, hs_act, vs_act;

  cnt_t     x_q, y_q;
  logic     de_q, ls_q, fs_q, hs_q, vs_q;

  assign h_ext  = {1'b0, h_cnt};
  assign v_ext  = {1'b0, v_cnt};
  assign h_wrap = (h_ext == H_LAST);
  assign v_wrap = (v_ext == V_LAST);

  always_ff @(posedge VGA_CLK or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_wrap ? '0 : h_cnt + cnt_t'(1);
      if (h_wrap) begin
        v_cnt <= v_wrap ? '0 : v_cnt + cnt_t'(1);
      end
    end
  end

  always_comb begin
    de_nxt = (h_ext < H_VIS_C) && (v_ext < V_VIS_C);
    hs_act = (h_ext >= HS_BEG) && (h_ext < HS_END);
    vs_act = (v_ext >= VS_BEG) && (v_ext < VS_END);
  end

  // Sync registers hold the output level so the delay lines only shift.
  always_ff @(posedge VGA_CLK or negedge rst_n) begin
    if (!rst_n) begin
      x_q  <= '0;
      y_q  <= '0;
      de_q <= 1'b0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
      hs_q <= ~H_POL;
      vs_q <= ~V_POL;
    end else begin
      x_q  <= h_cnt;
      y_q  <= v_cnt;
      de_q <= de_nxt;
      ls_q <= (h_cnt == '0);
      fs_q <= (h_cnt == '0) && (v_cnt == '0);
      hs_q <= hs_act ? H_POL : ~H_POL;
      vs_q <= vs_act ? V_POL : ~V_POL;
    end
  end

  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.disp_en     = de_q;
  assign vga.line_start  = ls_q;
  assign vga.frame_start = fs_q;

  vga_delay_line #(.DEPTH(SYNC_DLY), .RST_VAL(~H_POL)) u_hs_dly (
    .clk   (VGA_CLK),
    .rst_n (rst_n),
    .d     (hs_q),
    .q     (vga.h_sync)
  );

  vga_delay_line #(.DEPTH(SYNC_DLY), .RST_VAL(~V_POL)) u_vs_dly (
    .clk   (VGA_CLK),
    .rst_n (rst_n),
    .d     (vs_q),
    .q     (vga.v_sync)
  );

  vga_delay_line #(.DEPTH(SYNC_DLY), .RST_VAL(1'b0)) u_bn_dly (
    .clk   (VGA_CLK),
    .rst_n (rst_n),
    .d     (de_q),
    .q     (vga.blank_n)
  );

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default, short-frame, tiny active-low and SYNC_DLY=3 instances
// checked against expected values queued as the clock/reset stimulus is applied.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        de;
    logic        ls;
    logic        fs;
    logic        hs;
    logic        vs;
    logic        bn;
  } obs_t;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic rst_mid_n = 1'b0;
  int   checks    = 0;
  int   failures  = 0;
  obs_t sb_q[$];

  always #5 clk = ~clk;

  vga_timing_gen_if if_def ();
  vga_timing_gen_if if_mid ();
  vga_timing_gen_if if_small ();
  vga_timing_gen_if if_d3 ();

  vga_timing_gen u_def (.VGA_CLK(clk), .rst_n(rst_n), .vga(if_def));

  vga_timing_gen #(.V_VIS(4), .V_FP(1), .V_SYNC(3), .V_BP(2)) u_mid (
    .VGA_CLK(clk), .rst_n(rst_mid_n), .vga(if_mid));

  vga_timing_gen #(.H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_VIS(4), .V_FP(1),
                   .V_SYNC(1), .V_BP(2), .H_POL(1'b0), .V_POL(1'b0), .SYNC_DLY(0)) u_small (
    .VGA_CLK(clk), .rst_n(rst_n), .vga(if_small));

  vga_timing_gen #(.H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_VIS(4), .V_FP(1),
                   .V_SYNC(1), .V_BP(2), .H_POL(1'b1), .V_POL(1'b1), .SYNC_DLY(3)) u_d3 (
    .VGA_CLK(clk), .rst_n(rst_n), .vga(if_d3));

  obs_t o_def, o_mid, o_small, o_d3;
  assign o_def   = {if_def.x, if_def.y, if_def.disp_en, if_def.line_start, if_def.frame_start,
                    if_def.h_sync, if_def.v_sync, if_def.blank_n};
  assign o_mid   = {if_mid.x, if_mid.y, if_mid.disp_en, if_mid.line_start, if_mid.frame_start,
                    if_mid.h_sync, if_mid.v_sync, if_mid.blank_n};
  assign o_small = {if_small.x, if_small.y, if_small.disp_en, if_small.line_start,
                    if_small.frame_start, if_small.h_sync, if_small.v_sync, if_small.blank_n};
  assign o_d3    = {if_d3.x, if_d3.y, if_d3.disp_en, if_d3.line_start, if_d3.frame_start,
                    if_d3.h_sync, if_d3.v_sync, if_d3.blank_n};

  function automatic obs_t mk(input int x, input int y, input bit de, input bit ls,
                              input bit fs, input bit hs, input bit vs, input bit bn);
    obs_t o;
    o.x  = 11'(x);
    o.y  = 11'(y);
    o.de = de;
    o.ls = ls;
    o.fs = fs;
    o.hs = hs;
    o.vs = vs;
    o.bn = bn;
    return o;
  endfunction

  task automatic test_reset();
    obs_t exp;
    rst_n     = 1'b0;
    rst_mid_n = 1'b0;
    repeat (3) @(negedge clk);
    exp = mk(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (o_def !== exp) begin failures++; $display("FAIL reset_def got=%h exp=%h", o_def, exp); end
    checks++;
    if (o_mid !== exp) begin failures++; $display("FAIL reset_mid got=%h exp=%h", o_mid, exp); end
    checks++;
    if (o_d3 !== exp) begin failures++; $display("FAIL reset_d3 got=%h exp=%h", o_d3, exp); end
    exp = mk(0, 0, 0, 0, 0, 1, 1, 0);
    checks++;
    if (o_small !== exp) begin failures++; $display("FAIL reset_small got=%h exp=%h", o_small, exp); end

    rst_n = 1'b1;
    sb_q.delete();
    sb_q.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0));
    sb_q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1));
    sb_q.push_back(mk(2, 0, 1, 0, 0, 0, 0, 1));
    while (sb_q.size() > 0) begin
      @(negedge clk);
      exp = sb_q.pop_front();
      checks++;
      if (o_def !== exp) begin failures++; $display("FAIL reset_release got=%h exp=%h", o_def, exp); end
    end
  endtask

  task automatic test_horizontal();
    int exp_q[$];
    int cyc = 0, hs_cnt = 0, ls_last = -1, v;
    bit prev_de = 1'b1, prev_hs = 1'b0;
    bit f_de = 1'b0, f_hsr = 1'b0, f_hsw = 1'b0, f_ls = 1'b0;
    exp_q.push_back(1280);  // x where disp_en first reads low
    exp_q.push_back(1329);  // x where h_sync first reads high
    exp_q.push_back(112);   // h_sync high cycles
    exp_q.push_back(1688);  // line_start spacing
    while (!(f_de && f_hsr && f_hsw && f_ls) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (prev_de && !o_def.de && !f_de) begin
        f_de = 1'b1;
        v = exp_q.pop_front();
        checks++;
        if (int'(o_def.x) != v) begin failures++; $display("FAIL h_de_fall x=%0d exp=%0d", o_def.x, v); end
      end
      if (!prev_hs && o_def.hs && !f_hsr) begin
        f_hsr = 1'b1;
        hs_cnt = 0;
        v = exp_q.pop_front();
        checks++;
        if (int'(o_def.x) != v) begin failures++; $display("FAIL h_sync_rise x=%0d exp=%0d", o_def.x, v); end
      end
      if (f_hsr && !f_hsw) begin
        if (o_def.hs) hs_cnt++;
        else begin
          f_hsw = 1'b1;
          v = exp_q.pop_front();
          checks++;
          if (hs_cnt != v) begin failures++; $display("FAIL h_sync_width got=%0d exp=%0d", hs_cnt, v); end
        end
      end
      if (o_def.ls) begin
        if (ls_last >= 0 && !f_ls) begin
          f_ls = 1'b1;
          v = exp_q.pop_front();
          checks++;
          if (cyc - ls_last != v) begin
            failures++; $display("FAIL line_period got=%0d exp=%0d", cyc - ls_last, v);
          end
        end
        ls_last = cyc;
      end
      prev_de = o_def.de;
      prev_hs = o_def.hs;
    end
    while (exp_q.size() > 0) begin
      v = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL h_timeout pending_exp=%0d got=none", v);
    end
  endtask

  task automatic test_frame_wrap();
    int cyc = 0, fs_last = -1, vs_cnt = 0;
    bit prev_vs = 1'b0, pend = 1'b0;
    bit f_vsr = 1'b0, f_vsw = 1'b0, f_wrap = 1'b0, f_fs = 1'b0;
    obs_t exp;
    rst_mid_n = 1'b1;
    while (!(f_vsw && f_wrap && f_fs) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (pend) begin
        pend = 1'b0;
        f_wrap = 1'b1;
        exp = sb_q.pop_front();
        checks++;
        if (o_mid !== exp) begin failures++; $display("FAIL frame_wrap got=%h exp=%h", o_mid, exp); end
      end
      if (o_mid.x == 11'd1687 && o_mid.y == 11'd9 && !f_wrap) begin
        sb_q.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0));
        pend = 1'b1;
      end
      if (!prev_vs && o_mid.vs && !f_vsr) begin
        f_vsr = 1'b1;
        vs_cnt = 0;
        checks++;
        if (o_mid.x !== 11'd1 || o_mid.y !== 11'd5) begin
          failures++; $display("FAIL v_sync_start got x=%0d y=%0d exp x=1 y=5", o_mid.x, o_mid.y);
        end
      end
      if (f_vsr && !f_vsw) begin
        if (o_mid.vs) vs_cnt++;
        else begin
          f_vsw = 1'b1;
          checks++;
          if (vs_cnt != 3 * 1688) begin
            failures++; $display("FAIL v_sync_width got=%0d exp=%0d", vs_cnt, 3 * 1688);
          end
        end
      end
      if (o_mid.fs) begin
        if (fs_last >= 0 && !f_fs) begin
          f_fs = 1'b1;
          checks++;
          if (cyc - fs_last != 1688 * 10) begin
            failures++; $display("FAIL frame_period got=%0d exp=%0d", cyc - fs_last, 1688 * 10);
          end
        end
        fs_last = cyc;
      end
      prev_vs = o_mid.vs;
    end
    if (!(f_vsw && f_wrap && f_fs)) begin
      checks++;
      failures++;
      $display("FAIL frame_timeout got vs=%0d wrap=%0d fs=%0d exp all 1", f_vsw, f_wrap, f_fs);
    end
  endtask

  task automatic test_mid_reset();
    int cyc = 0;
    obs_t exp;
    while (!(o_mid.x == 11'd500 && o_mid.y == 11'd3) && cyc < 8000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (o_mid.x !== 11'd500 || o_mid.y !== 11'd3) begin
      failures++; $display("FAIL mid_reach got x=%0d y=%0d exp x=500 y=3", o_mid.x, o_mid.y);
    end
    @(posedge clk);
    #2;
    rst_mid_n = 1'b0;
    #1;
    exp = mk(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (o_mid !== exp) begin failures++; $display("FAIL mid_reset_async got=%h exp=%h", o_mid, exp); end
    @(negedge clk);
    @(negedge clk);
    rst_mid_n = 1'b1;
    sb_q.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0));
    sb_q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1));
    while (sb_q.size() > 0) begin
      @(negedge clk);
      exp = sb_q.pop_front();
      checks++;
      if (o_mid !== exp) begin failures++; $display("FAIL mid_restart got=%h exp=%h", o_mid, exp); end
    end
  endtask

  task automatic test_small_config();
    int hc, vc, fs_last = -1;
    bit de;
    obs_t exp;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 256; n++) begin
      hc = n % 16;
      vc = (n / 16) % 8;
      de = (hc < 8) && (vc < 4);
      // active-low syncs: h_sync low on x=10..12, v_sync low through line 5
      sb_q.push_back(mk(hc, vc, de, hc == 0, hc == 0 && vc == 0,
                        !(hc >= 10 && hc <= 12), vc != 5, de));
      @(negedge clk);
      exp = sb_q.pop_front();
      checks++;
      if (o_small !== exp) begin
        failures++; $display("FAIL small_cycle n=%0d got=%h exp=%h", n, o_small, exp);
      end
      if (o_small.fs) begin
        if (fs_last >= 0) begin
          checks++;
          if (n - fs_last != 128) begin
            failures++; $display("FAIL small_frame_period got=%0d exp=128", n - fs_last);
          end
        end
        fs_last = n;
      end
    end
  endtask

  task automatic test_sync_delay();
    int hc, vc;
    bit de;
    logic [2:0] dq[$];
    logic [2:0] raw, dly;
    obs_t exp;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) dq.push_back(3'b000);
    for (int n = 0; n < 136; n++) begin
      hc = n % 16;
      vc = (n / 16) % 8;
      de = (hc < 8) && (vc < 4);
      raw = {hc >= 10 && hc <= 12, vc == 5, de};
      dq.push_back(raw);
      dly = dq.pop_front();
      sb_q.push_back(mk(hc, vc, de, hc == 0, hc == 0 && vc == 0, dly[2], dly[1], dly[0]));
      @(negedge clk);
      exp = sb_q.pop_front();
      checks++;
      if (o_d3 !== exp) begin
        failures++; $display("FAIL dly3_cycle n=%0d got=%h exp=%h", n, o_d3, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_frame_wrap();
    test_mid_reset();
    test_small_config();
    test_sync_delay();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator for the VGA output path; the source end of the pixel-coordinate interface consumed by the colour/pattern blocks.
- Free-running horizontal and vertical counters produce x, y and disp_en for the colour stage.
- Also produces h_sync, v_sync and blank_n, delayed to line up with the registered RGB from the colour stage, for the DAC/connector.
- Default mode is 1280x1024 at 60 Hz with a 108 MHz VGA_CLK.

Parameters:
- H_VIS, 1280, visible pixels per line
- H_FP, 48, horizontal front porch (clocks)
- H_SYNC, 112, horizontal sync width (clocks)
- H_BP, 248, horizontal back porch (clocks)
- V_VIS, 1024, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 3, vertical sync width (lines)
- V_BP, 38, vertical back porch (lines)
- H_POL, 1, h_sync active level (1 = active-high)
- V_POL, 1, v_sync active level
- SYNC_DLY, 1, extra cycles applied to h_sync/v_sync/blank_n relative to x/y/disp_en (0..4)

Ports:
- VGA_CLK  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- x  out  11  horizontal counter value, raw, 0..H_TOTAL-1
- y  out  11  vertical counter value, raw, 0..V_TOTAL-1
- disp_en  out  1  high when x<H_VIS and y<V_VIS
- line_start  out  1  one-cycle pulse when x==0, every line including blanking lines
- frame_start  out  1  one-cycle pulse when x==0 and y==0
- h_sync  out  1  horizontal sync, polarity H_POL, delayed by SYNC_DLY
- v_sync  out  1  vertical sync, polarity V_POL, delayed by SYNC_DLY
- blank_n  out  1  delayed copy of disp_en (SYNC_DLY); DAC blanking

Behaviour:
- Reset and clock: one clock (VGA_CLK); reset is asynchronous and active-low (rst_n).
- Derived totals: H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (default 1688); V_TOTAL likewise (default 1066). Both totals must be ≤2048; the build must fail an elaboration check otherwise.
- Counters: internal h_cnt and v_cnt, 11 bits each.
  - h_cnt increments every clock and wraps from H_TOTAL-1 to 0.
  - v_cnt increments only on that wrap and wraps from V_TOTAL-1 to 0 on the same edge that h_cnt wraps.
- Output stage 1 (all outputs registered from the counters, so they lag the counters by one cycle):
  - x = h_cnt, y = v_cnt.
  - disp_en = (h_cnt<H_VIS) && (v_cnt<V_VIS).
  - line_start = (h_cnt==0); frame_start = (h_cnt==0 && v_cnt==0).
  - Raw sync terms use the same counter sample:
    - hs_raw is active for H_VIS+H_FP ≤ h_cnt < H_VIS+H_FP+H_SYNC.
    - vs_raw is active for V_VIS+V_FP ≤ v_cnt < V_VIS+V_FP+V_SYNC, for the whole line including its horizontal blanking.
- Delay stage:
  - hs_raw, vs_raw and disp_en each pass through a SYNC_DLY-deep shift register to h_sync, v_sync and blank_n.
  - SYNC_DLY=0 means direct connection from output stage 1.
  - The default of 1 matches the colour stage's single RGB register.
- Reset values:
  - h_cnt=0, v_cnt=0; x=0, y=0.
  - disp_en=0, line_start=0, frame_start=0.
  - h_sync=!H_POL, v_sync=!V_POL, blank_n=0, and every shift-register stage holds its inactive value.
- First edge after rst_n rises: x=0, y=0, disp_en=1, line_start=1, frame_start=1. With SYNC_DLY=1, blank_n=1 one edge later.
- Reset mid-frame: asynchronous; all outputs go to reset values immediately. The next frame restarts at (0,0) with no partial line.
- No enable input; the block free-runs whenever out of reset.

Decomposition:
- Package vga_timing_pkg holds:
  - localparams for the 1280x1024@60 defaults;
  - a 640x480@60 set (800x525) for bring-up;
  - a function computing H_TOTAL/V_TOTAL.
- One sub-module, vga_delay_line: a parametric-depth 1-bit shift register with async reset and a reset-value parameter, instantiated three times. SYNC_DLY=0 yields a pass-through.

Test Plan:
- Reset: hold rst_n=0 with VGA_CLK running -> x=0, y=0, disp_en=0, h_sync=0, v_sync=0, blank_n=0. Release -> first edge gives x=0, y=0, disp_en=1, frame_start=1; next edge blank_n=1.
- Horizontal timing (defaults): disp_en falls at x=1280. h_sync is high exactly 112 cycles, rising one cycle after x=1328 is presented. Line period is 1688 clocks; line_start spacing is 1688.
- Line/frame wrap: x=1687, y=1065 -> next cycle x=0, y=0, frame_start=1. v_sync high for 3 full lines, starting 1 cycle after y=1025 with x=0 appears; frame period 1688*1066 clocks.
- Small config (H_VIS=8, H_FP=2, H_SYNC=3, H_BP=3, V_VIS=4, V_FP=1, V_SYNC=1, V_BP=2, H_POL=V_POL=0, SYNC_DLY=0):
  - h_sync low exactly at x=10..12;
  - v_sync low for all of y=5;
  - 16*8 clocks per frame.
- Mid-frame reset: assert rst_n low asynchronously at x=500, y=300 -> outputs reset within the same cycle. After release, the sequence restarts at (0,0) with frame_start.
- SYNC_DLY=3: blank_n and h_sync equal disp_en and hs_raw shifted by exactly 3 cycles. The first 3 cycles after reset show inactive values.
